axi_line_fill: RTL and testbench
================================

# axi_line_fill

Read-burst engine between the cache and the AXI4 memory port. When the cache raises `miss`, the engine issues one INCR burst for the missing 128-byte line and streams each returned word back as `mem_addr`/`mem_data_in`/`mem_data_valid`/`mem_last`. It holds off re-triggering until the cache drops `miss`. Single outstanding burst, read-only; the cache's write-allocate merge happens inside the cache.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `LINE_BYTES`, 128: cache line size. Power of two, multiple of 4. Beats per burst = `LINE_BYTES/4` (32 at default).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `miss`  in  1  cache miss request, held high until the fill completes.
- `fill_addr`  in  ADDR_W  CPU address of the missing access; low log2(LINE_BYTES) bits ignored.
- `mem_addr`  out  ADDR_W  byte address of the word on `mem_data_in`; equals `fill_addr` when idle.
- `mem_data_in`  out  32  returned word; 0 when `mem_data_valid`=0.
- `mem_wstb`  out  4  constant 4'b1111.
- `mem_data_valid`  out  1  one-cycle strobe per returned word.
- `mem_last`  out  1  high with the final word's strobe only.
- `araddr`  out  ADDR_W  line-aligned burst address.
- `arlen`  out  8  `LINE_BYTES/4 - 1`.
- `arsize`  out  3  3'b010.
- `arburst`  out  2  2'b01 (INCR).
- `arvalid`  out  1  AR request.
- `arready`  in  1  AR accept.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response.
- `rlast`  in  1  slave last-beat flag.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.
- `resp_err`  out  1  sticky: any beat had `rresp` != 2'b00.
- `proto_err`  out  1  sticky: `rlast` disagreed with the beat count.

## Operation

- States: IDLE, ADDR, DATA, RELEASE.
- IDLE:
  - `arvalid`=0, `rready`=0, `mem_addr`=`fill_addr` (combinational pass-through).
  - When `miss`=1, latch base = `fill_addr` with low log2(LINE_BYTES) bits cleared, clear the beat counter, go to ADDR.
- ADDR:
  - `arvalid`=1 and `araddr`=base, both held stable until `arready`.
  - On `arvalid && arready`, go to DATA.
- DATA:
  - `rready`=1 continuously.
  - Each `rvalid && rready` beat n (n = 0..BEATS-1) produces registered outputs the next cycle: `mem_data_in`=`rdata`, `mem_addr`=base + 4n, `mem_data_valid`=1.
  - The beat counter increments per beat and wraps at BEATS. The address sum is ADDR_W bits and never wraps within a line.
  - On beat BEATS-1, `mem_last`=1 with that strobe, then go to RELEASE.
- RELEASE:
  - Outputs idle. Wait for `miss`=0, then go to IDLE. This blocks a re-fill from the stale `miss` level.
- Errors:
  - `rresp` != 0 on any beat sets `resp_err`. The data is still forwarded.
  - `rlast`=1 on beat n<BEATS-1, or `rlast`=0 on beat BEATS-1, sets `proto_err`.
  - The beat count alone terminates the burst; extra or short slave beats are not tracked further.
  - Both error flags clear only on `reset`.
- `miss` falling during ADDR or DATA is a cache protocol violation. The engine ignores it and completes the burst.

## Timing

- Reset asserted (async): state IDLE; `arvalid`, `rready`, `mem_data_valid`, `mem_last`, `resp_err`, `proto_err` = 0; `mem_data_in`=0; `araddr`=0; counter=0.
- Reset mid-burst aborts immediately with no drain. Reset is also applied to the AXI slave.
- Latency:
  - `miss` sampled high in IDLE → `arvalid`=1 in the next cycle.
  - R handshake at edge k → `mem_data_valid`=1 in the cycle after edge k.
- Zero-wait slave, full line: the first AR cycle is 1 cycle after `miss`; the final `mem_last` arrives after BEATS consecutive data cycles.
- Back-to-back `rvalid` produces back-to-back `mem_data_valid` with no bubbles.
- `mem_last` falls exactly one cycle after it rises. The cache drops `miss` on that same edge.
- Earliest next AR is 2 cycles after `miss` falls (RELEASE→IDLE→ADDR).

## Test plan

- `fill_addr`=0x0000_1234, `miss` held, `arready`=1, zero-wait R with `rdata`=0xA0+n → `araddr`=0x0000_1200, `arlen`=31, `arsize`=2, `arburst`=1; 32 strobes with `mem_addr` 0x1200..0x127C and data 0xA0..0xBF; `mem_last` only on 0x127C.
- `arready` delayed 5 cycles, `rvalid` toggling every other cycle → `araddr` stable across the stall; exactly 32 strobes, each one cycle after its handshake; no strobe without a handshake.
- `miss` still high for 3 cycles after `mem_last` → stays in RELEASE, no second `arvalid`; new `miss` pulse afterwards → new burst.
- `rresp`=2'b10 on beat 7, `rlast` on beat 30 → `resp_err`=1 and `proto_err`=1, both sticky; all 32 words still delivered.
- `reset` asserted on beat 12 → same-cycle `arvalid`/`rready`/`mem_data_valid`=0, state IDLE; next `miss` restarts at beat 0.
- Idle with `miss`=0, `fill_addr` varying → `mem_addr` tracks `fill_addr`; `mem_data_in`=0; `mem_wstb`=4'b1111.

Source files
------------

// File: rtl/axi_line_fill.sv
// axi_line_fill: single-outstanding AXI4 INCR read burst that fills one cache line and streams it back word by word
module axi_line_fill #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_wstb,
  output logic              mem_data_valid,
  output logic              mem_last,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              resp_err,
  output logic              proto_err
);
  localparam int BEATS = LINE_BYTES / 4;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] LMASK = ADDR_W'(LINE_BYTES - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RELEASE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, resp_err_q, resp_err_d, proto_err_q, proto_err_d;
  logic is_last;
  assign is_last = cnt_q == CW'(BEATS - 1);
  assign arvalid = state_q == ADDR;
  assign rready = state_q == DATA;
  assign araddr = base_q;
  assign arlen = 8'(BEATS - 1);
  assign arsize = 3'b010;
  assign arburst = 2'b01;
  assign mem_wstb = 4'b1111;
  assign mem_addr = state_q == IDLE ? fill_addr : addr_q;
  assign mem_data_in = data_q;
  assign mem_data_valid = valid_q;
  assign mem_last = last_q;
  assign resp_err = resp_err_q;
  assign proto_err = proto_err_q;
  // Next state: latch line base on miss, issue AR, forward each R beat as a registered strobe, then wait for miss to drop
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = '0;
    valid_d = 1'b0;
    last_d = 1'b0;
    resp_err_d = resp_err_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: if (miss) begin
        state_d = ADDR;
        base_d = fill_addr & ~LMASK;
        cnt_d = '0;
      end
      ADDR: if (arready) state_d = DATA;
      DATA: if (rvalid) begin
        data_d = rdata;
        addr_d = base_q + (ADDR_W'(cnt_q) << 2);
        valid_d = 1'b1;
        last_d = is_last;
        cnt_d = is_last ? '0 : cnt_q + 1'b1;
        resp_err_d = resp_err_q | (rresp != 2'b00);
        proto_err_d = proto_err_q | (rlast != is_last);
        state_d = is_last ? RELEASE : DATA;
      end
      RELEASE: if (!miss) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset aborts any burst in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      resp_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      resp_err_q <= resp_err_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_axi_line_fill.sv
// tb_axi_line_fill: scoreboard bench driving an AXI slave model against axi_line_fill
module tb_axi_line_fill;
  logic clk = 1'b0, reset = 1'b1, miss = 1'b0;
  logic [31:0] fill_addr = '0, mem_addr, mem_data_in, araddr, rdata = '0;
  logic [3:0] mem_wstb;
  logic mem_data_valid, mem_last, arvalid, arready = 1'b0, rready, resp_err, proto_err;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp = '0;
  logic rlast = 1'b0, rvalid = 1'b0;
  int vectors = 0, miscompares = 0, strobes = 0, exp_n = 0;
  logic [31:0] exp_base = '0;
  logic hs_q = 1'b0;
  logic [64:0] sb[$];
  axi_line_fill dut (
    .clk(clk), .reset(reset), .miss(miss), .fill_addr(fill_addr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
    .mem_data_valid(mem_data_valid), .mem_last(mem_last),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .resp_err(resp_err), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Push the expected word for every R handshake the slave model completes
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      exp_n = 0;
      hs_q <= 1'b0;
    end else begin
      hs_q <= rvalid && rready;
      if (rvalid && rready) begin
        sb.push_back({exp_base + 32'(exp_n * 4), rdata, exp_n == 31});
        exp_n = exp_n == 31 ? 0 : exp_n + 1;
      end
    end
  end
  // Compare strobes against the scoreboard and their timing against the handshakes
  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_timing", 65'(mem_data_valid), 65'(hs_q));
      if (mem_data_valid) begin
        strobes++;
        if (sb.size() == 0) chk("sb_underflow", 65'(1), 65'(0));
        else chk("beat", {mem_addr, mem_data_in, mem_last}, sb.pop_front());
      end else chk("data_idle", 65'(mem_data_in), 65'(0));
    end
  end
  task automatic ar_phase(input int delay, input logic [31:0] exp_araddr, output int t);
    t = 0;
    while (!arvalid && t < 50) begin
      tick;
      t++;
    end
    chk("ar_seen", 65'(arvalid), 65'(1));
    chk("ar_fields", {araddr, arlen, arsize, arburst}, {exp_araddr, 8'd31, 3'd2, 2'd1});
    for (int i = 0; i < delay; i++) begin
      tick;
      chk("ar_stable", {arvalid, araddr}, {1'b1, exp_araddr});
    end
    arready = 1'b1;
    tick;
    arready = 1'b0;
  endtask
  task automatic r_phase(input int gap, input int err_beat, input int rlast_beat, input int stop_beat);
    for (int n = 0; n < stop_beat; n++) begin
      for (int g = 0; g < gap; g++) tick;
      rvalid = 1'b1;
      rdata = 32'hA0 + 32'(n);
      rresp = n == err_beat ? 2'b10 : 2'b00;
      rlast = n == rlast_beat;
      tick;
      rvalid = 1'b0;
      rlast = 1'b0;
      rresp = 2'b00;
    end
  endtask
  task automatic burst(input logic [31:0] fa, input int delay, input int gap, input int err_beat, input int rlast_beat);
    int t, s0;
    s0 = strobes;
    fill_addr = fa;
    exp_base = fa & ~32'h7F;
    miss = 1'b1;
    tick;
    ar_phase(delay, exp_base, t);
    chk("ar_latency", 65'(t), 65'(0));
    r_phase(gap, err_beat, rlast_beat, 32);
    tick;
    chk("strobe_count", 65'(strobes - s0), 65'(32));
    chk("sb_drained", 65'(sb.size()), 65'(0));
  endtask
  task automatic release_miss;
    miss = 1'b0;
    tick;
    tick;
    chk("no_rearm", 65'(arvalid), 65'(0));
  endtask
  initial begin
    int t;
    #2;
    chk("reset_outs", {arvalid, rready, mem_data_valid, mem_last, resp_err, proto_err, mem_data_in, araddr},
        65'(0));
    tick;
    reset = 1'b0;
    tick;
    burst(32'h0000_1234, 0, 0, -1, 31);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("release_hold", 65'(arvalid), 65'(0));
    end
    release_miss;
    burst(32'h0000_5678, 5, 1, -1, 31);
    release_miss;
    chk("errs_clean", {resp_err, proto_err}, 65'(0));
    burst(32'h8000_00C4, 0, 0, 7, 30);
    release_miss;
    chk("errs_set", {resp_err, proto_err}, 65'(3));
    burst(32'h0000_2000, 2, 0, -1, 31);
    release_miss;
    chk("errs_sticky", {resp_err, proto_err}, 65'(3));
    fill_addr = 32'h0000_3F10;
    exp_base = 32'h0000_3F00;
    miss = 1'b1;
    tick;
    ar_phase(0, 32'h0000_3F00, t);
    r_phase(0, -1, 31, 12);
    @(negedge clk);
    #1;
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    #1;
    reset = 1'b1;
    #1;
    chk("reset_abort", {arvalid, rready, mem_data_valid, mem_addr}, {3'b000, 32'h0000_3F10});
    chk("reset_errs", {resp_err, proto_err}, 65'(0));
    tick;
    rvalid = 1'b0;
    reset = 1'b0;
    burst(32'h0000_4444, 0, 0, -1, 31);
    release_miss;
    for (int i = 0; i < 4; i++) begin
      fill_addr = 32'h1357_9BDF * 32'(i + 1);
      #1;
      chk("idle_pass", {mem_addr, mem_data_in, mem_wstb}, {fill_addr, 32'h0, 4'hF});
      tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
